reg_scoreboard: RTL

Register-file scoreboard and operand bypass for the MIPS core. It sits between decode/issue and the 32×32 register file. It tracks outstanding writes to each architectural register and stalls issue on read-after-write hazards. It forwards same-cycle writeback data so an issuing instruction never reads a stale value from the register file's combinational read ports. It observes the register file's write port and is the consumer side of that write interface.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/reg_pending_ctr.sv | 29 ++
 rtl/reg_scoreboard.sv | 116 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core constants and types used by the register-file scoreboard.
package mips_pkg;

  localparam int unsigned REG_IDX_W      = 5;
  localparam int unsigned NUM_REGS       = 32;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned STALL_W        = 32;
  localparam int unsigned PEND_W_DEFAULT = 2;

  function automatic int unsigned pend_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned PEND_MAX = pend_max(PEND_W_DEFAULT);

  // Snooped register-file write port.
  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] index;
    logic [DATA_W-1:0]    data;
  } wb_req_t;

endpackage

// File: rtl/reg_pending_ctr.sv
// Per-register outstanding-write counter: saturating up/down with clear and underflow detect.
module reg_pending_ctr #(
  parameter int unsigned PEND_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] count,
  output logic              underflow_c
);

  localparam logic [PEND_W-1:0] CNT_FULL = '1;

  // A lone decrement at zero is a writeback nobody was waiting for.
  assign underflow_c = dec && !inc && (count == '0);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && !dec && (count != CNT_FULL)) begin
      count <= count + PEND_W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - PEND_W'(1);
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-file scoreboard: RAW/WAW-depth stall, same-cycle writeback bypass and stall statistics.
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int unsigned PEND_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [REG_IDX_W-1:0] issue_src1,
  input  logic [REG_IDX_W-1:0] issue_src2,
  input  logic                 issue_use1,
  input  logic                 issue_use2,
  input  logic                 issue_writes,
  input  logic [REG_IDX_W-1:0] issue_dest,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_index,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic [DATA_W-1:0]    rf_data1,
  input  logic [DATA_W-1:0]    rf_data2,
  output logic [DATA_W-1:0]    operand1,
  output logic [DATA_W-1:0]    operand2,
  output logic [STALL_W-1:0]   stall_cycles,
  output logic                 wb_underflow
);

  localparam int unsigned       PEND_LIMIT = pend_max(PEND_W);
  localparam logic [PEND_W-1:0] PEND_FULL  = PEND_W'(PEND_LIMIT);
  localparam logic [STALL_W-1:0] STALL_SAT = '1;

  wb_req_t                wb;
  logic [PEND_W-1:0]      pend [NUM_REGS];
  logic [NUM_REGS-1:1]    inc_vec;
  logic [NUM_REGS-1:1]    dec_vec;
  logic [NUM_REGS-1:1]    uf_vec;
  logic                   haz_src1;
  logic                   haz_src2;
  logic                   haz_dest;
  logic                   accept;

  assign wb = '{valid: wb_valid, index: wb_index, data: wb_data};

  // A source waits unless its single outstanding write lands this very cycle.
  function automatic logic src_hazard(input logic used, input logic [REG_IDX_W-1:0] src,
                                      input logic [PEND_W-1:0] cnt, input wb_req_t w);
    if (!used || (src == '0) || (cnt == '0)) begin
      return 1'b0;
    end
    return !((cnt == PEND_W'(1)) && w.valid && (w.index == src));
  endfunction

  function automatic logic [DATA_W-1:0] bypass(input logic [REG_IDX_W-1:0] src,
                                               input wb_req_t w,
                                               input logic [DATA_W-1:0] rf);
    if (src == '0) begin
      return '0;
    end
    if (w.valid && (w.index == src)) begin
      return w.data;
    end
    return rf;
  endfunction

  always_comb begin
    haz_src1 = src_hazard(issue_use1, issue_src1, pend[issue_src1], wb);
    haz_src2 = src_hazard(issue_use2, issue_src2, pend[issue_src2], wb);
    haz_dest = 1'b0;
    if (issue_writes && (issue_dest != '0) && (pend[issue_dest] == PEND_FULL)) begin
      haz_dest = !(wb.valid && (wb.index == issue_dest));
    end
  end

  assign issue_ready = !reset && !flush && !haz_src1 && !haz_src2 && !haz_dest;
  assign accept      = issue_valid && issue_ready;
  assign operand1    = bypass(issue_src1, wb, rf_data1);
  assign operand2    = bypass(issue_src2, wb, rf_data2);

  // r0 is hardwired zero: no counter, never pending.
  assign pend[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_ctr
    assign inc_vec[r] = accept && issue_writes && (issue_dest == REG_IDX_W'(r));
    assign dec_vec[r] = wb.valid && (wb.index == REG_IDX_W'(r));

    reg_pending_ctr #(
      .PEND_W(PEND_W)
    ) u_ctr (
      .clk         (clk),
      .reset       (reset),
      .clear       (flush),
      .inc         (inc_vec[r]),
      .dec         (dec_vec[r]),
      .count       (pend[r]),
      .underflow_c (uf_vec[r])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (issue_valid && !issue_ready && (stall_cycles != STALL_SAT)) begin
      stall_cycles <= stall_cycles + STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_underflow <= 1'b0;
    end else if (|uf_vec) begin
      wb_underflow <= 1'b1;
    end
  end

endmodule
